// File: rtl/cr_kme_unpack_pkg.sv
// rtl/cr_kme_unpack_pkg.sv - shared field positions and state encoding for the KME word unpacker
package cr_kme_unpack_pkg;

    localparam int SOT_BIT   = 131;
    localparam int EOT_BIT   = 130;
    localparam int CNT_LSB   = 128;
    localparam int PAYLOAD_W = 128;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } unpack_state_e;

endpackage

// File: rtl/cr_kme_unpack_frame_chk.sv
// rtl/cr_kme_unpack_frame_chk.sv - SOT/EOT framing tracker with a one-cycle frame_err pulse
module cr_kme_unpack_frame_chk (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic load_sot,
    input  logic eot_accept,
    output logic frame_err
);

    logic in_frame;
    logic frame_live;

    // An EOT beat accepted in the same cycle as the next load closes the frame first,
    // so back-to-back frames are not flagged.
    assign frame_live = in_frame & ~eot_accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_frame  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= load & (load_sot ? frame_live : ~frame_live);
            if (load && load_sot) begin
                in_frame <= 1'b1;
            end else if (eot_accept) begin
                in_frame <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cr_kme_word_unpacker.sv
// rtl/cr_kme_word_unpacker.sv - pops 132-bit staging words and streams BEAT_SIZE-bit beats with SOT/EOT
// Optional framing checker: define CR_KME_UNPACK_ERRCHK_EN.
module cr_kme_word_unpacker
    import cr_kme_unpack_pkg::*;
#(
    parameter int DATA_SIZE = 132,
    parameter int BEAT_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ack,
    output logic [BEAT_SIZE-1:0] out_data,
    output logic                 out_sot,
    output logic                 out_eot,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int BEATS = PAYLOAD_W / BEAT_SIZE;
    localparam int IDX_W = $clog2(BEATS);
    localparam logic [IDX_W-1:0] LAST_FULL = IDX_W'(BEATS - 1);

    unpack_state_e state;
    unpack_state_e state_d;

    logic [PAYLOAD_W-1:0] hold_payload;
    logic                 hold_sot;
    logic                 hold_eot;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     last;
    logic [IDX_W-1:0]     load_last;
    logic                 beat_accept;
    logic                 word_done;
    logic                 load;
    logic [BEAT_SIZE-1:0] beat_slice [BEATS];

    // With 64-bit beats only the low count bit is meaningful.
    logic unused_cnt;
    assign unused_cnt = ^in_data[CNT_LSB +: 2];

    assign out_valid   = (state == EMIT);
    assign busy        = (state == EMIT);
    assign beat_accept = out_valid & out_ready;
    assign word_done   = beat_accept & (idx == last);
    assign in_ack      = in_valid & ((state == IDLE) | word_done);
    assign load        = in_ack;
    assign load_last   = in_data[EOT_BIT] ? in_data[CNT_LSB +: IDX_W] : LAST_FULL;

    for (genvar b = 0; b < BEATS; b++) begin : g_slice
        assign beat_slice[b] = hold_payload[b*BEAT_SIZE +: BEAT_SIZE];
    end

    assign out_data = beat_slice[idx];
    assign out_sot  = out_valid & hold_sot & (idx == '0);
    assign out_eot  = out_valid & hold_eot & (idx == last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid) state_d = EMIT;
            EMIT:    if (word_done && !in_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every acked word is captured in the same cycle, so load also covers the back-to-back case.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_payload <= '0;
            hold_sot     <= 1'b0;
            hold_eot     <= 1'b0;
            idx          <= '0;
            last         <= '0;
        end else if (load) begin
            hold_payload <= in_data[PAYLOAD_W-1:0];
            hold_sot     <= in_data[SOT_BIT];
            hold_eot     <= in_data[EOT_BIT];
            idx          <= '0;
            last         <= load_last;
        end else if (beat_accept && (idx != last)) begin
            idx <= idx + IDX_W'(1);
        end
    end

`ifdef CR_KME_UNPACK_ERRCHK_EN
    cr_kme_unpack_frame_chk u_frame_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_sot   (in_data[SOT_BIT]),
        .eot_accept (beat_accept & out_eot),
        .frame_err  (frame_err)
    );
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: doc/cr_kme_word_unpacker.md
# cr_kme_word_unpacker

Downstream consumer of the 132-bit KME staging FIFO. It pops one 132-bit word at a time (128 payload bits plus 4 framing bits) and emits the payload as a stream of BEAT_SIZE-bit beats on a valid/ready interface, with start-of-frame and end-of-frame markers. It drives the FIFO's read-acknowledge directly and sustains one beat per cycle with no bubble between consecutive words.

## Interface
- DATA_SIZE, 132, input word width; fixed: 128 payload bits plus 4 framing bits.
- BEAT_SIZE, 32, output beat width; legal values are 32 and 64. BEATS = 128/BEAT_SIZE.
- clk  input  1  sole clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  132  FIFO head word.
  - [127:0] payload.
  - [129:128] valid beats minus 1; meaningful only when EOT is set; only bit 128 is used when BEAT_SIZE=64.
  - [130] EOT.
  - [131] SOT.
- in_valid  input  1  FIFO not empty.
- in_ack  output  1  pop the FIFO head this cycle; combinational.
- out_data  output  BEAT_SIZE  beat payload.
- out_sot  output  1  first beat of a frame.
- out_eot  output  1  last beat of a frame.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts the beat.
- busy  output  1  a word is held (state EMIT).
- frame_err  output  1  one-cycle framing-error pulse.

## Operation
- States:
  - IDLE: no word held.
  - EMIT: holding register `hold` is valid; beat index `idx` and last index `last` are live.
- Load: capture in_data into `hold` and set idx=0.
  - last = in_data[129:128] (truncated to log2(BEATS) bits) if EOT is set, else BEATS-1.
- in_ack = in_valid & (state==IDLE | (out_valid & out_ready & idx==last)). Every acked word is loaded in the same cycle.
- IDLE with in_valid → load, go to EMIT.
- EMIT with out_ready:
  - If idx<last: idx++.
  - If idx==last and in_valid: load the next word and stay in EMIT (back-to-back, no bubble).
  - If idx==last and !in_valid: go to IDLE.
- EMIT with !out_ready: hold all state. out_data, out_sot and out_eot stay stable while out_valid & !out_ready.
- out_valid = (state==EMIT).
- out_data = hold[idx*BEAT_SIZE +: BEAT_SIZE]. Beat 0 is the least-significant slice.
- out_sot = hold[131] & idx==0.
- out_eot = hold[130] & idx==last.
- A single-word frame (SOT and EOT both set) is legal.
- Beats beyond `last` on an EOT word are never emitted.
- Without an EOT, a word always emits all BEATS beats; the count field is ignored.

## Timing
- Reset values:
  - state IDLE, idx 0, hold 0.
  - out_valid 0, out_data 0, out_sot 0, out_eot 0.
  - busy 0, frame_err 0, in_ack 0.
- Latency: a word acked in cycle N presents beat 0 in cycle N+1.
- Throughput: one beat per cycle. A full word occupies BEATS cycles when out_ready is held high.
- in_ack never asserts while in_valid is low. Underflow is impossible by construction.
- Reset asserted mid-word drops the held word. No beat is emitted after reset, and the FIFO on the same rst_n is flushed with it.

## Configuration
- CR_KME_UNPACK_ERRCHK_EN defined: framing checker is present.
  - It tracks `in_frame`: set on loading a SOT word, cleared when the EOT beat is accepted.
  - frame_err pulses high in the cycle after a load of either:
    - a SOT word while in_frame=1;
    - a non-SOT word while in_frame=0.
  - The erroneous word is still emitted unchanged.
- CR_KME_UNPACK_ERRCHK_EN undefined: no checker logic; frame_err is tied to 0.

## Structure
- Package cr_kme_unpack_pkg holds:
  - localparams SOT_BIT=131, EOT_BIT=130, CNT_LSB=128, PAYLOAD_W=128;
  - the state enum {IDLE, EMIT}.
- Sub-module cr_kme_unpack_frame_chk holds the in_frame tracker and frame_err register. It is instantiated only under CR_KME_UNPACK_ERRCHK_EN.

## Test plan
- Single word, SOT|EOT, cnt=3, payload 0x44444444_33333333_22222222_11111111, out_ready=1:
  - beats 0x11111111 (sot), 0x22222222, 0x33333333, 0x44444444 (eot) in cycles N+1..N+4;
  - in_ack high in cycle N only.
- Two words queued, out_ready=1:
  - 8 consecutive valid beats with no gap;
  - second in_ack coincides with the acceptance of beat 3.
- EOT word with cnt=1 → exactly 2 beats, second flagged eot. Next word loads right after beat 1.
- out_ready toggled 1,0,0,1 during beat 2 → out_data/out_sot/out_eot stable across the stall; beat 3 follows the accept.
- rst_n low for one cycle during beat 1 → cycle after reset: out_valid=0, busy=0. The next word starts at beat 0.
- With CR_KME_UNPACK_ERRCHK_EN:
  - SOT, SOT, EOT word sequence → frame_err one-cycle pulse after the second load;
  - a non-SOT word from IDLE → frame_err pulse.
